// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the MIPS-subset pipeline.
// It captures the operands, the specifiers, PC+4 and the decoded control of the ID instruction.
// It detects a load-use hazard against the load that is in EX and loads a bubble for it.
// Flush and hold requests take priority over the hazard: flush first, then hold.
// A saturating counter tracks how many load-use bubbles were inserted.
//
// Handshake: there is no valid/ready pair. id_valid qualifies the ID contents. A register
// update happens on every clock edge unless hold is high. lu_stall is combinational and tells
// the upstream stages to keep PC and IF/ID for this cycle. The stalled instruction is then
// presented again on the next cycle.
module id_ex_reg #(
    parameter int DW     = 32,
    parameter int CTRL_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DW-1:0]     id_pc4,
    input  logic [DW-1:0]     id_rs_data,
    input  logic [DW-1:0]     id_rt_data,
    input  logic [DW-1:0]     id_imm_ext,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic              id_uses_rt,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DW-1:0]     ex_pc4,
    output logic [DW-1:0]     ex_rs_data,
    output logic [DW-1:0]     ex_rt_data,
    output logic [DW-1:0]     ex_imm_ext,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              lu_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int MEMREAD_BIT = 1;

    logic [1:0] rst_sync;
    logic       rst_int_n;
    logic       hazard;
    logic       dp_load;

    // Reset synchronizer: the reset asserts asynchronously and releases two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // A load in EX whose destination is a source of the ID instruction. The $zero register is excluded.
    assign hazard = ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt != 5'd0) & id_valid &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    // A stall only matters when the register is actually advancing.
    assign lu_stall = hazard & ~hold & ~flush;

    // Datapath fields follow id_* whenever the register advances.
    // Bubbles carry junk data, which is harmless because valid and ctrl are cleared.
    assign dp_load = flush | ~hold;

    // Datapath register: plain pass-through with no arithmetic.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm_ext <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_shamt   <= '0;
        end else if (dp_load) begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm_ext <= id_imm_ext;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_shamt   <= id_shamt;
        end
    end

    // Valid and control use the priority flush > hold > load-use > load. A bubble never carries control.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (hold) begin
            ex_valid <= ex_valid;
            ex_ctrl  <= ex_ctrl;
        end else if (lu_stall) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

    // Bubble counter: counts load-use bubbles only and saturates at all-ones.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            bubble_cnt <= '0;
        end else if (lu_stall && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg.
// The driver task applies one vector per cycle. It also pushes the hand-computed response for that vector.
// A monitor process pops each response and checks both the combinational and the registered outputs.
module tb_id_ex_reg;

    localparam int DW     = 32;
    localparam int CTRL_W = 11;
    localparam int CNT_W  = 4;

    localparam logic [10:0] C_LW  = 11'h11B;
    localparam logic [10:0] C_ADD = 11'h121;

    typedef struct {
        logic        lu;
        logic        valid;
        logic [10:0] ctrl;
        logic [3:0]  cnt;
        logic        dp_chk;
        logic [31:0] pc4;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [DW-1:0]     id_pc4;
    logic [DW-1:0]     id_rs_data;
    logic [DW-1:0]     id_rt_data;
    logic [DW-1:0]     id_imm_ext;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [4:0]        id_shamt;
    logic              id_uses_rt;
    logic [CTRL_W-1:0] id_ctrl;
    logic              hold;
    logic              flush;
    logic              ex_valid;
    logic [DW-1:0]     ex_pc4;
    logic [DW-1:0]     ex_rs_data;
    logic [DW-1:0]     ex_rt_data;
    logic [DW-1:0]     ex_imm_ext;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [4:0]        ex_shamt;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              lu_stall;
    logic [CNT_W-1:0]  bubble_cnt;

    exp_t exp_q[$];
    exp_t last_dp;
    int   n_total;
    int   n_pass;

    id_ex_reg #(.DW(DW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc4(id_pc4),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl), .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_ctrl(ex_ctrl), .lu_stall(lu_stall),
        .bubble_cnt(bubble_cnt)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Driver task. Mode 0 leaves the datapath unchecked (bubble).
    // Mode 1 expects this vector's data. Mode 2 expects the last loaded data (hold).
    task automatic apply(input logic v, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urt, input logic [10:0] ctrl,
                         input logic hd, input logic fl,
                         input logic e_lu, input logic e_valid, input logic [10:0] e_ctrl,
                         input logic [3:0] e_cnt, input int mode);
        exp_t e;
        @(negedge clk);
        id_valid   = v;
        id_pc4     = pc4;
        id_rs_data = pc4 + 32'h1000_0000;
        id_rt_data = pc4 + 32'h2000_0000;
        id_imm_ext = imm;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_shamt   = rd ^ 5'h15;
        id_uses_rt = urt;
        id_ctrl    = ctrl;
        hold       = hd;
        flush      = fl;
        e.pc4 = id_pc4; e.rsd = id_rs_data; e.rtd = id_rt_data; e.imm = id_imm_ext;
        e.rs = id_rs; e.rt = id_rt; e.rd = id_rd; e.sh = id_shamt;
        if (mode == 2) e = last_dp;
        if (mode == 1) last_dp = e;
        e.dp_chk = (mode != 0);
        e.lu = e_lu; e.valid = e_valid; e.ctrl = e_ctrl; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    task automatic lw_i(input logic [31:0] pc4, input logic [4:0] rs, input logic [4:0] rt,
                        input logic e_lu, input logic [3:0] e_cnt);
        apply(1'b1, pc4, pc4 + 32'h30, rs, rt, 5'd0, 1'b0, C_LW, 1'b0, 1'b0,
              e_lu, 1'b1, C_LW, e_cnt, 1);
    endtask

    // Monitor: checks lu_stall just before the edge and the registered outputs just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("lu_stall", {31'd0, lu_stall}, {31'd0, e.lu});
                @(posedge clk);
                #1;
                chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
                chk("ex_ctrl", {21'd0, ex_ctrl}, {21'd0, e.ctrl});
                chk("bubble_cnt", {28'd0, bubble_cnt}, {28'd0, e.cnt});
                if (e.dp_chk) begin
                    chk("ex_pc4", ex_pc4, e.pc4);
                    chk("ex_rs_data", ex_rs_data, e.rsd);
                    chk("ex_rt_data", ex_rt_data, e.rtd);
                    chk("ex_imm_ext", ex_imm_ext, e.imm);
                    chk("ex_rs", {27'd0, ex_rs}, {27'd0, e.rs});
                    chk("ex_rt", {27'd0, ex_rt}, {27'd0, e.rt});
                    chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
                    chk("ex_shamt", {27'd0, ex_shamt}, {27'd0, e.sh});
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_ctrl"}, {21'd0, ex_ctrl}, 32'd0);
        chk({tag, "_pc4"}, ex_pc4, 32'd0);
        chk({tag, "_rs_data"}, ex_rs_data, 32'd0);
        chk({tag, "_rt_data"}, ex_rt_data, 32'd0);
        chk({tag, "_imm"}, ex_imm_ext, 32'd0);
        chk({tag, "_regs"}, {12'd0, ex_rs, ex_rt, ex_rd, ex_shamt}, 32'd0);
        chk({tag, "_cnt"}, {28'd0, bubble_cnt}, 32'd0);
    endtask

    // Main sequence
    initial begin
        logic [3:0] cnt_e;
        n_total = 0; n_pass = 0;
        rst_n = 1'b0;
        id_valid = 0; id_pc4 = 0; id_rs_data = 0; id_rt_data = 0; id_imm_ext = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_uses_rt = 0; id_ctrl = 0;
        hold = 0; flush = 0;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("rst_init");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Pass-through of a sign-extended immediate
        apply(1, 32'h4, 32'hFFFF_8000, 5'd1, 5'd2, 5'd3, 0, 11'h011, 0, 0, 0, 1, 11'h011, 4'd0, 1);
        // Load-use on rs: one bubble, then the stalled add advances
        lw_i(32'h8, 5'd1, 5'd5, 0, 4'd0);
        apply(1, 32'hC, 32'h40, 5'd5, 5'd6, 5'd7, 1, C_ADD, 0, 0, 1, 0, 11'h000, 4'd1, 0);
        apply(1, 32'hC, 32'h40, 5'd5, 5'd6, 5'd7, 1, C_ADD, 0, 0, 0, 1, C_ADD, 4'd1, 1);
        // A load to $zero never stalls
        lw_i(32'h10, 5'd2, 5'd0, 0, 4'd1);
        apply(1, 32'h14, 32'h44, 5'd0, 5'd0, 5'd8, 1, C_ADD, 0, 0, 0, 1, C_ADD, 4'd1, 1);
        // An rt match does not stall when rt is not a source
        lw_i(32'h18, 5'd3, 5'd7, 0, 4'd1);
        apply(1, 32'h1C, 32'h48, 5'd1, 5'd7, 5'd9, 0, C_ADD, 0, 0, 0, 1, C_ADD, 4'd1, 1);
        // An rt match does stall when rt is a source
        lw_i(32'h20, 5'd3, 5'd7, 0, 4'd1);
        apply(1, 32'h24, 32'h4C, 5'd1, 5'd7, 5'd10, 1, C_ADD, 0, 0, 1, 0, 11'h000, 4'd2, 0);
        apply(1, 32'h24, 32'h4C, 5'd1, 5'd7, 5'd10, 1, C_ADD, 0, 0, 0, 1, C_ADD, 4'd2, 1);
        // Flush with hold during a hazard: bubble loaded, no stall, count unchanged
        lw_i(32'h28, 5'd4, 5'd5, 0, 4'd2);
        apply(1, 32'h2C, 32'h50, 5'd5, 5'd6, 5'd11, 1, C_ADD, 1, 1, 0, 0, 11'h000, 4'd2, 0);
        // Hold for three cycles during a hazard: EX stays stable
        lw_i(32'h30, 5'd4, 5'd5, 0, 4'd2);
        repeat (3)
            apply(1, 32'h34, 32'h54, 5'd5, 5'd6, 5'd12, 1, C_ADD, 1, 0, 0, 1, C_LW, 4'd2, 2);
        apply(1, 32'h34, 32'h54, 5'd5, 5'd6, 5'd12, 1, C_ADD, 0, 0, 1, 0, 11'h000, 4'd3, 0);
        apply(1, 32'h34, 32'h54, 5'd5, 5'd6, 5'd12, 1, C_ADD, 0, 0, 0, 1, C_ADD, 4'd3, 1);
        // An invalid ID instruction loads with its control cleared
        apply(0, 32'h38, 32'h58, 5'd1, 5'd2, 5'd13, 1, C_ADD, 0, 0, 0, 0, 11'h000, 4'd3, 1);
        // Saturation: 20 load-use pairs
        cnt_e = 4'd3;
        for (int i = 0; i < 20; i++) begin
            lw_i(32'h100 + 8 * i, 5'd1, 5'd5, 0, cnt_e);
            if (cnt_e != 4'hF) cnt_e = cnt_e + 4'd1;
            apply(1, 32'h104 + 8 * i, 32'h60, 5'd5, 5'd2, 5'd14, 0, C_ADD, 0, 0,
                  1, 0, 11'h000, cnt_e, 0);
        end
        lw_i(32'h200, 5'd1, 5'd9, 0, 4'hF);
        repeat (3) @(posedge clk);

        // Asynchronous reset mid-stream while ex_valid is 1
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        chk("rst_lu_stall", {31'd0, lu_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        apply(1, 32'h44, 32'h7FFF, 5'd3, 5'd4, 5'd5, 0, 11'h011, 0, 0, 0, 1, 11'h011, 4'd0, 1);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
